// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: mult/multu/div/divu with fixed busy
// durations, plus single-edge mthi/mtlo writes.
module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // Datapath operates only on latched operands, so later A/B changes are invisible.
    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_den;
    logic [31:0] uquot, urem, quot, rem;

    always_comb begin
        ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = ext_a * ext_b;

        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;
        // Zero divisor never commits, but keep the divider free of X.
        b_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uquot = a_mag / b_den;
        urem  = a_mag % b_den;
        quot  = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
        rem   = a_neg ? (~urem + 32'd1) : urem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (mdop)
                        OP_MULT, OP_MULTU: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (mdop == OP_MULT);
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (mdop == OP_DIV);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for single operations plus
// hand-written sequences for ignored starts, reset abort and back-to-back issue.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one op, scramble operands after acceptance, count busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = 32'h5A5A_A5A5;
        B     = 32'hC3C3_3C3C;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        int cnt;
        logic [11:0] pat;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mdop   = 3'd0;
        A      = '0;
        B      = '0;

        vecs[0]  = '{"mult_neg1x2",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{"multu_maxx2",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{"div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_7_2",     3'd3, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[4]  = '{"div_min_m1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{"mult_maxpos",  3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{"div_7_m2",     3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7]  = '{"mthi",         3'd4, 32'h1111_1111, 32'h0000_0000, 0,  32'h1111_1111, 32'hFFFF_FFFD};
        vecs[8]  = '{"mtlo",         3'd5, 32'h2222_2222, 32'h0000_0000, 0,  32'h1111_1111, 32'h2222_2222};
        vecs[9]  = '{"divu_by0",     3'd3, 32'h0000_0064, 32'h0000_0000, 10, 32'h1111_1111, 32'h2222_2222};
        vecs[10] = '{"div_by0",      3'd2, 32'hFFFF_FF00, 32'h0000_0000, 10, 32'h1111_1111, 32'h2222_2222};
        vecs[11] = '{"reserved6",    3'd6, 32'hDEAD_BEEF, 32'h0000_0003, 0,  32'h1111_1111, 32'h2222_2222};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check32("reset_hi", HI, 32'h0);
        check32("reset_lo", LO, 32'h0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            check_int({vecs[i].name, "_busy"}, nb, vecs[i].exp_busy);
            check32({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
            check32({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
        end

        // Starts during busy (div on cycle 2, mtlo on the final cycle) are ignored.
        @(negedge clk);
        start = 1'b1; mdop = 3'd0; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            start = 1'b0;
            if (cnt == 2) begin
                start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd3;
            end else if (cnt == 5) begin
                start = 1'b1; mdop = 3'd5; A = 32'h0000_DEAD;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_int("ignore_busy", cnt, 5);
        check32("ignore_hi", HI, 32'h0);
        check32("ignore_lo", LO, 32'd15);
        repeat (3) @(negedge clk);
        check_int("ignore_after_busy", int'(busy), 0);
        check32("ignore_after_lo", LO, 32'd15);

        // Reset on busy cycle 4 of a div abandons it without any write.
        @(negedge clk);
        start = 1'b1; mdop = 3'd3; A = 32'd50; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 4) begin
            cnt++;
            if (cnt == 4) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        check_int("rst_reached_cycle4", cnt, 4);
        check_int("rst_busy", int'(busy), 0);
        check32("rst_hi", HI, 32'h0);
        check32("rst_lo", LO, 32'h0);
        repeat (12) @(negedge clk);
        check32("rst_late_hi", HI, 32'h0);
        check32("rst_late_lo", LO, 32'h0);

        // Continuously held start: five busy cycles, one idle cycle, repeat.
        @(negedge clk);
        start = 1'b1; mdop = 3'd0; A = 32'd2; B = 32'd3;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            pat[11-k] = busy;
        end
        start = 1'b0;
        check32("b2b_pattern", {20'h0, pat}, {20'h0, 12'b111110111110});
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check32("b2b_hi", HI, 32'h0);
        check32("b2b_lo", LO, 32'd6);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check32("div_min_again_lo", LO, 32'h8000_0000);
        check32("div_min_again_hi", HI, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
